mic_ram_write_arbiter: RTL and testbench

// - Shares the single ram_logic write port (write_data_i/write_valid_i/write_ready_o) between N I2S sample streams.
// - Streams: left/right of several i2s_capture_24 instances.
// - One-deep holding register per channel; round-robin grant; zero-pads 24-bit samples to 32-bit RAM words.
// - Sits between the i2s_capture_24 instances and ram_logic; reports per-channel sample loss.

---
 rtl/mic_ram_write_arbiter.sv | 112 +++++++++++
 tb/tb_mic_ram_write_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_ram_write_arbiter.sv
// Round-robin arbiter sharing the ram_logic write port between N_CH I2S sample channels.
// Optional MIC_ARB_CH_TAG_EN: upper 8 bits of each RAM word carry the source channel index.
module mic_ram_write_arbiter #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 24,
  parameter int WORD_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_CH*DATA_W-1:0]   ch_data_i,
  input  logic [N_CH-1:0]          ch_valid_i,
  input  logic [N_CH-1:0]          ch_enable_i,
  output logic [WORD_W-1:0]        ram_data_o,
  output logic                     ram_valid_o,
  input  logic                     ram_ready_i,
  output logic [N_CH-1:0]          grant_o,
  output logic [N_CH-1:0]          overflow_o,
  input  logic                     clr_overflow_i
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int unsigned N_U = N_CH;

  typedef enum logic {ST_IDLE, ST_OFFER} state_t;

  state_t              state;
  logic [N_CH-1:0]     pend;
  logic [DATA_W-1:0]   hold [N_CH];
  logic [IDX_W-1:0]    rr;

  logic [N_CH-1:0]     cand;
  logic [N_CH-1:0]     grant_now;
  logic [N_CH-1:0]     drop;
  logic                arb_en;
  logic                sel_found;
  logic [IDX_W-1:0]    sel;
  logic [IDX_W-1:0]    idx;
  logic [WORD_W-1:0]   next_word;

  // Disabled channels are excluded from arbitration so their pending sample is discarded.
  always_comb begin
    cand      = pend & ch_enable_i;
    arb_en    = (state == ST_IDLE) || ram_ready_i;
    sel_found = 1'b0;
    sel       = '0;
    idx       = '0;
    for (int unsigned i = 1; i <= N_U; i++) begin
      idx = IDX_W'((32'(rr) + i) % N_U);
      if (!sel_found && cand[idx]) begin
        sel_found = 1'b1;
        sel       = idx;
      end
    end

    grant_now = '0;
    if (arb_en && sel_found) grant_now[sel] = 1'b1;

    drop = ch_valid_i & ch_enable_i & pend & ~grant_now;

    next_word = '0;
    next_word[DATA_W-1:0] = hold[sel];
`ifdef MIC_ARB_CH_TAG_EN
    next_word[WORD_W-1 -: 8] = 8'(sel);
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      rr          <= IDX_W'(N_CH - 1);
      pend        <= '0;
      ram_data_o  <= '0;
      ram_valid_o <= 1'b0;
      grant_o     <= '0;
      overflow_o  <= '0;
      for (int unsigned c = 0; c < N_U; c++) hold[c] <= '0;
    end else begin
      if (arb_en) begin
        if (sel_found) begin
          state       <= ST_OFFER;
          ram_valid_o <= 1'b1;
          ram_data_o  <= next_word;
          grant_o     <= grant_now;
          rr          <= sel;
        end else begin
          state       <= ST_IDLE;
          ram_valid_o <= 1'b0;
          ram_data_o  <= '0;
          grant_o     <= '0;
        end
      end

      // A strobe on the channel's own grant edge refills the just-emptied holding register.
      for (int unsigned c = 0; c < N_U; c++) begin
        if (!ch_enable_i[c]) begin
          pend[c] <= 1'b0;
        end else if (ch_valid_i[c]) begin
          if (!pend[c] || grant_now[c]) begin
            hold[c] <= ch_data_i[c*DATA_W +: DATA_W];
            pend[c] <= 1'b1;
          end
        end else if (grant_now[c]) begin
          pend[c] <= 1'b0;
        end
      end

      if (clr_overflow_i) overflow_o <= '0;
      else                overflow_o <= overflow_o | drop;
    end
  end

endmodule

// File: tb/tb_mic_ram_write_arbiter.sv
// Directed self-checking bench for mic_ram_write_arbiter (4 channels, 24-bit samples, 32-bit words).
// Expected words follow MIC_ARB_CH_TAG_EN when the bench is built with that macro.
module tb_mic_ram_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [95:0] ch_data_i;
  logic [3:0]  ch_valid_i;
  logic [3:0]  ch_enable_i;
  logic [31:0] ram_data_o;
  logic        ram_valid_o;
  logic        ram_ready_i;
  logic [3:0]  grant_o;
  logic [3:0]  overflow_o;
  logic        clr_overflow_i;

  int n_checks = 0;
  int n_fail   = 0;

  mic_ram_write_arbiter #(.N_CH(4), .DATA_W(24), .WORD_W(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ch_data_i      (ch_data_i),
    .ch_valid_i     (ch_valid_i),
    .ch_enable_i    (ch_enable_i),
    .ram_data_o     (ram_data_o),
    .ram_valid_o    (ram_valid_o),
    .ram_ready_i    (ram_ready_i),
    .grant_o        (grant_o),
    .overflow_o     (overflow_o),
    .clr_overflow_i (clr_overflow_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input int unsigned ch, input logic [23:0] s);
`ifdef MIC_ARB_CH_TAG_EN
    return {8'(ch), s};
`else
    return {8'h00, s};
`endif
  endfunction

  function automatic logic [23:0] samp(input int unsigned ch);
    return 24'(24'h111111 * (ch + 1)) ^ 24'h00A5A5;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_sample(input int unsigned ch, input logic [23:0] s);
    ch_data_i[ch*24 +: 24] = s;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #12;
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ram_valid_o); end
    n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL rst_grant: got %b want 0000", grant_o); end
    n_checks++; if (ram_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 00000000", ram_data_o); end
    rst_ni = 1'b1;
    tick();
    // Three ch2 strobes with the port stalled: second lands on the grant edge, third overflows.
    ram_ready_i = 1'b0;
    set_sample(2, 24'h222222);
    ch_valid_i = 4'b0100;
    tick();
    tick();
    n_checks++; if (ram_valid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid: got %b want 1", ram_valid_o); end
    n_checks++; if (grant_o !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant: got %b want 0100", grant_o); end
    tick();
    ch_valid_i = 4'b0000;
    n_checks++; if (overflow_o !== 4'b0100) begin n_fail++; $display("FAIL rstmid_ovf_set: got %b want 0100", overflow_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", ram_valid_o); end
    n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL async_grant: got %b want 0000", grant_o); end
    n_checks++; if (overflow_o !== 4'b0000) begin n_fail++; $display("FAIL async_ovf: got %b want 0000", overflow_o); end
    #2 rst_ni = 1'b1;
    ram_ready_i = 1'b1;
    for (int unsigned c = 0; c < 4; c++) set_sample(c, samp(c));
    ch_valid_i = 4'b1111;
    tick();
    ch_valid_i = 4'b0000;
    tick();
    n_checks++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL post_rst_first_grant: got %b want 0001", grant_o); end
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_drain: got %b want 0", ram_valid_o); end
  endtask

  task automatic run_contention(input string tag, input int unsigned o0, input int unsigned o1,
                                input int unsigned o2, input int unsigned o3);
    int unsigned order [4];
    order = '{o0, o1, o2, o3};
    ram_ready_i = 1'b1;
    for (int unsigned c = 0; c < 4; c++) set_sample(c, samp(c));
    ch_valid_i = 4'b1111;
    tick();
    ch_valid_i = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (ram_valid_o !== 1'b1) begin n_fail++; $display("FAIL %s_valid[%0d]: got %b want 1", tag, k, ram_valid_o); end
      n_checks++; if (grant_o !== 4'(1 << order[k])) begin n_fail++; $display("FAIL %s_grant[%0d]: got %b want %b", tag, k, grant_o, 4'(1 << order[k])); end
      n_checks++; if (ram_data_o !== exp_word(order[k], samp(order[k]))) begin n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", tag, k, ram_data_o, exp_word(order[k], samp(order[k]))); end
    end
    tick();
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_idle: got %b want 0", tag, ram_valid_o); end
  endtask

  task automatic test_contention();
    run_contention("cont_ptr3", 0, 1, 2, 3);
    // A lone ch1 transfer leaves the pointer at 1.
    set_sample(1, 24'h0F0F0F);
    ch_valid_i = 4'b0010;
    tick();
    ch_valid_i = 4'b0000;
    tick();
    n_checks++; if (grant_o !== 4'b0010) begin n_fail++; $display("FAIL cont_ptr_setup: got %b want 0010", grant_o); end
    tick();
    run_contention("cont_ptr1", 2, 3, 0, 1);
  endtask

  task automatic test_single();
    ram_ready_i = 1'b1;
    set_sample(2, 24'hABCDEF);
    ch_valid_i = 4'b0100;
    tick();
    ch_valid_i = 4'b0000;
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: got %b want 0", ram_valid_o); end
    tick();
    n_checks++; if (ram_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", ram_valid_o); end
    n_checks++; if (ram_data_o !== exp_word(2, 24'hABCDEF)) begin n_fail++; $display("FAIL single_data: got %h want %h", ram_data_o, exp_word(2, 24'hABCDEF)); end
`ifndef MIC_ARB_CH_TAG_EN
    n_checks++; if (ram_data_o !== 32'h00ABCDEF) begin n_fail++; $display("FAIL single_data_abs: got %h want 00abcdef", ram_data_o); end
`endif
    n_checks++; if (grant_o !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant_o); end
    tick();
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b want 0", ram_valid_o); end
    n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL single_grant_idle: got %b want 0000", grant_o); end
  endtask

  task automatic test_backpressure();
    logic exp_ovf;
    ram_ready_i = 1'b0;
    set_sample(1, 24'h1A1A1A);
    ch_valid_i = 4'b0010;
    tick();
    ch_valid_i = 4'b0000;
    tick();
    // Window: B fills the empty holding reg, C overflows, D overflows with clear -> clear wins.
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin set_sample(1, 24'h2B2B2B); ch_valid_i = 4'b0010; end
      if (k == 5) begin set_sample(1, 24'h3C3C3C); ch_valid_i = 4'b0010; end
      if (k == 7) begin set_sample(1, 24'h4D4D4D); ch_valid_i = 4'b0010; clr_overflow_i = 1'b1; end
      tick();
      ch_valid_i = 4'b0000;
      clr_overflow_i = 1'b0;
      exp_ovf = (k >= 5 && k < 7);
      n_checks++; if (ram_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", k, ram_valid_o); end
      n_checks++; if (ram_data_o !== exp_word(1, 24'h1A1A1A)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", k, ram_data_o, exp_word(1, 24'h1A1A1A)); end
      n_checks++; if (grant_o !== 4'b0010) begin n_fail++; $display("FAIL bp_grant[%0d]: got %b want 0010", k, grant_o); end
      n_checks++; if (overflow_o[1] !== exp_ovf) begin n_fail++; $display("FAIL bp_ovf[%0d]: got %b want %b", k, overflow_o[1], exp_ovf); end
    end
    ram_ready_i = 1'b1;
    tick();
    n_checks++; if (ram_data_o !== exp_word(1, 24'h2B2B2B)) begin n_fail++; $display("FAIL bp_second_data: got %h want %h", ram_data_o, exp_word(1, 24'h2B2B2B)); end
    n_checks++; if (grant_o !== 4'b0010) begin n_fail++; $display("FAIL bp_second_grant: got %b want 0010", grant_o); end
    tick();
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drop_never_sent: got %b want 0", ram_valid_o); end
    n_checks++; if (overflow_o !== 4'b0000) begin n_fail++; $display("FAIL bp_ovf_final: got %b want 0000", overflow_o); end
  endtask

  task automatic test_granted_strobe();
    ram_ready_i = 1'b1;
    set_sample(0, 24'hC0FFEE);
    ch_valid_i = 4'b0001;
    tick();
    set_sample(0, 24'h0BEEF0);
    tick();
    ch_valid_i = 4'b0000;
    n_checks++; if (ram_data_o !== exp_word(0, 24'hC0FFEE)) begin n_fail++; $display("FAIL gs_first: got %h want %h", ram_data_o, exp_word(0, 24'hC0FFEE)); end
    n_checks++; if (grant_o !== 4'b0001) begin n_fail++; $display("FAIL gs_first_grant: got %b want 0001", grant_o); end
    tick();
    n_checks++; if (ram_data_o !== exp_word(0, 24'h0BEEF0)) begin n_fail++; $display("FAIL gs_second: got %h want %h", ram_data_o, exp_word(0, 24'h0BEEF0)); end
    n_checks++; if (ram_valid_o !== 1'b1) begin n_fail++; $display("FAIL gs_second_valid: got %b want 1", ram_valid_o); end
    tick();
    n_checks++; if (overflow_o[0] !== 1'b0) begin n_fail++; $display("FAIL gs_ovf: got %b want 0", overflow_o[0]); end
    n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL gs_idle: got %b want 0", ram_valid_o); end
  endtask

  task automatic test_disable();
    ram_ready_i = 1'b0;
    set_sample(2, 24'h2D2D2D);
    set_sample(3, 24'h3D3D3D);
    ch_valid_i = 4'b1100;
    tick();
    ch_valid_i = 4'b0000;
    tick();
    n_checks++; if (grant_o !== 4'b0100) begin n_fail++; $display("FAIL dis_grant2: got %b want 0100", grant_o); end
    ch_enable_i = 4'b0111;
    tick();
    ch_enable_i = 4'b1111;
    ram_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (ram_valid_o !== 1'b0) begin n_fail++; $display("FAIL dis_valid[%0d]: got %b want 0", k, ram_valid_o); end
      n_checks++; if (grant_o !== 4'b0000) begin n_fail++; $display("FAIL dis_grant[%0d]: got %b want 0000", k, grant_o); end
    end
    n_checks++; if (overflow_o !== 4'b0000) begin n_fail++; $display("FAIL dis_ovf: got %b want 0000", overflow_o); end
  endtask

  task automatic test_tag();
    logic [31:0] want;
`ifdef MIC_ARB_CH_TAG_EN
    want = 32'h03000001;
`else
    want = 32'h00000001;
`endif
    ram_ready_i = 1'b1;
    set_sample(3, 24'h000001);
    ch_valid_i = 4'b1000;
    tick();
    ch_valid_i = 4'b0000;
    tick();
    n_checks++; if (ram_data_o !== want) begin n_fail++; $display("FAIL tag_data: got %h want %h", ram_data_o, want); end
    n_checks++; if (grant_o !== 4'b1000) begin n_fail++; $display("FAIL tag_grant: got %b want 1000", grant_o); end
    tick();
  endtask

  initial begin
    ch_data_i      = '0;
    ch_valid_i     = '0;
    ch_enable_i    = 4'b1111;
    ram_ready_i    = 1'b1;
    clr_overflow_i = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_granted_strobe();
    test_disable();
    test_tag();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
